// File: rtl/cla_nibble_seq_ctrl.sv
// Sequences a WIDTH-bit add/subtract through one external 4-bit CLA slice,
// one nibble per clock (LSB first), then reports the result with carry and signed-overflow flags.
module cla_nibble_seq_ctrl #(
  parameter  int WIDTH = 32,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [IDXW+1:0]   bit_base;

  assign bit_base = {idx_q, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the slice only ever adds.
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[bit_base +: 4] = cla_sum;
        carry_d              = cla_cout;
        if (idx_q == LAST_IDX) begin
          // Carry into the MSB is a^b^s at that bit; overflow is that carry xor carry-out.
          cout_d  = cla_cout;
          ovf_d   = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1] ^ cla_sum[3] ^ cla_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cla_a   = 4'd0;
    cla_b   = 4'd0;
    cla_cin = 1'b0;
    if (state_q == RUN) begin
      cla_a   = op_a_q[bit_base +: 4];
      cla_b   = op_b_q[bit_base +: 4];
      cla_cin = carry_q;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
